core_if: RTL and testbench
==========================

// Module: core_if
// PURPOSE
//  Instruction fetch stage. Writer side of the instruction interface that the decode stage consumes.
//  Owns the PC and issues word reads to instruction memory over a req/gnt/rvalid protocol.
//  Buffers returned words with their addresses and presents {inst_out, inst_addr_out} downstream under valid/ready.
//  Handles redirects (jump/branch) from execute and stalls (hold) from the pipeline controller.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  FIFO_DEPTH  2              buffered instructions; also the maximum in-flight plus buffered count (power of 2, >=2)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   reset, asynchronous, active-low
//  imem_req_out     out  1   read request valid
//  imem_addr_out    out  32  read address (word aligned)
//  imem_gnt_in      in   1   request accepted this cycle
//  imem_rvalid_in   in   1   read data valid; responses in order, >=1 cycle after gnt
//  imem_rdata_in    in   32  read data
//  jump_flag_in     in   1   redirect PC this cycle
//  jump_addr_in     in   32  redirect target
//  hold_in          in   1   suppress new requests (in-flight ones still complete)
//  inst_valid_out   out  1   inst_out/inst_addr_out valid
//  inst_ready_in    in   1   downstream accepts when valid&ready
//  inst_out         out  32  instruction word; `INST_NOP when invalid
//  inst_addr_out    out  32  address of inst_out; `ZeroWord when invalid
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_PC, FIFO empty, in_flight=0, discard=0.
//   imem_req_out=0, inst_valid_out=0, inst_out=`INST_NOP, inst_addr_out=0.
//  Credit: occupancy = fifo_count + in_flight.
//   imem_req_out = !hold_in & !jump_flag_in & occupancy < FIFO_DEPTH; imem_addr_out = pc.
//   Combinational from registered state plus hold/jump.
//  req&gnt: pc <= pc+4 (wraps at 2^32), in_flight++.
//   req without gnt: hold pc/addr stable next cycle unless a jump occurs.
//  rvalid: in_flight--. If discard>0: discard--, data dropped.
//   Otherwise push {rdata, addr}; addr comes from an internal response-address queue, depth FIFO_DEPTH.
//   Push is guaranteed non-full by the credit rule.
//  Latency: word returned in cycle N is visible on inst_* in cycle N+1. No bypass.
//  Downstream: inst_valid_out = FIFO non-empty; pop on valid&ready. Push and pop in the same cycle are legal.
//  Jump (jump_flag_in=1):
//   pc <= {jump_addr_in[31:2], 2'b00} (misalignment silently truncated).
//   FIFO flushed; inst_valid_out=0 next cycle.
//   discard <= in_flight (+1 if a gnt occurs in the same cycle, -1 if a rvalid occurs in the same cycle).
//   No request is issued in the jump cycle.
//  Jump during hold: redirect applies. Fetch resumes at the new PC when hold drops.
//  Back-to-back jumps: last one wins; discard accumulates correctly.
//  rvalid with in_flight==0: protocol error; ignored, counters saturate at 0. Simulation $error.
//  Reset mid-operation: all state cleared immediately. Any later rvalid from the pre-reset transaction is ignored by the rule above.
// STRUCTURE
//  defines.v: `InstByteBus, `InstAddressBus, `INST_NOP (32'h0000_0013), `ZeroWord, `IF_RESET_PC.
//  Sub-module core_if_fifo: synchronous FIFO, WIDTH=64 (inst+addr), DEPTH=FIFO_DEPTH.
//   Ports: flush, push, pop, full, empty, count.
//  Top level holds pc, in_flight, discard and the address queue.
// TESTING
//  1. Reset release, zero-wait memory (gnt=1, rvalid next cycle), ready=1:
//     req addrs 0x0,0x4,0x8; inst_addr_out 0x0,0x4,0x8 on consecutive cycles.
//  2. ready=0 for 6 cycles: exactly FIFO_DEPTH requests issued, then req=0.
//     On ready=1: entries drain in order with no gaps or duplicates.
//  3. Jump to 0x100 with 2 requests in flight: both responses dropped.
//     The next valid output is inst_addr_out=0x100.
//  4. jump_addr_in=0x103: next imem_addr_out=0x100.
//  5. gnt held low for 3 cycles: addr stable at 0x8.
//     hold_in=1: req=0 while already-issued responses are still accepted.
//  6. rst asserted mid-stream with 1 in flight: outputs reset at once.
//     A stale rvalid after release is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/core_if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package core_if_pkg;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } fetch_entry_t;

  // Drop the byte offset of a redirect target; misaligned targets are truncated.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/core_if_fifo.sv
// Synchronous FIFO holding fetched instructions. Flush empties it in one cycle
// and overrides any push or pop in that same cycle.
module core_if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // storage array; contents are only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_if.sv
// Instruction fetch stage: owns the PC, issues word reads over req/gnt/rvalid,
// and hands {instruction, address} pairs downstream under valid/ready.
module core_if
  import core_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IF_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  input  logic        jump_flag_in,
  input  logic [31:0] jump_addr_in,
  input  logic        hold_in,
  output logic        inst_valid_out,
  input  logic        inst_ready_in,
  output logic [31:0] inst_out,
  output logic [31:0] inst_addr_out
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] in_flight_nxt;
  logic [CW-1:0] discard;
  logic          fetch_en;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  fifo_wdata;
  fetch_entry_t  fifo_rdata;

  logic [31:0]   aq_mem [FIFO_DEPTH];
  logic [AW-1:0] aq_wr;
  logic [AW-1:0] aq_rd;

  logic          req_fire;
  logic          rvalid_ok;

  // Every outstanding request owns a FIFO slot, so a response can always be stored.
  assign occupancy     = {1'b0, fifo_count} + {1'b0, in_flight};
  assign imem_req_out  = fetch_en & ~hold_in & ~jump_flag_in & (occupancy < CREDITS);
  assign imem_addr_out = pc;
  assign req_fire      = imem_req_out & imem_gnt_in;

  // A response with nothing outstanding (e.g. left over from before a reset) is ignored.
  assign rvalid_ok     = imem_rvalid_in & (in_flight != '0);
  assign in_flight_nxt = in_flight + CW'(req_fire) - CW'(rvalid_ok);

  // Responses belonging to a pre-redirect request are dropped; a redirect in the
  // same cycle flushes the FIFO, so nothing arriving then is kept either.
  assign fifo_push       = rvalid_ok & (discard == '0) & ~jump_flag_in & ~fifo_full;
  assign fifo_wdata.inst = imem_rdata_in;
  assign fifo_wdata.addr = aq_mem[aq_rd];
  assign fifo_pop        = inst_valid_out & inst_ready_in;

  assign inst_valid_out = ~fifo_empty;
  assign inst_out       = fifo_empty ? INST_NOP  : fifo_rdata.inst;
  assign inst_addr_out  = fifo_empty ? ZERO_WORD : fifo_rdata.addr;

  core_if_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (jump_flag_in),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // response-address queue storage: one entry per granted, not yet answered request
  always_ff @(posedge clk) begin
    if (req_fire) begin
      aq_mem[aq_wr] <= pc;
    end
  end

  // response-address queue pointers; responses return in order so a ring suffices
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aq_wr <= '0;
      aq_rd <= '0;
    end else begin
      if (req_fire)  aq_wr <= aq_wr + 1'b1;
      if (rvalid_ok) aq_rd <= aq_rd + 1'b1;
    end
  end

  // PC, outstanding-request and discard bookkeeping; fetch_en keeps req low while in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      in_flight <= '0;
      discard   <= '0;
      fetch_en  <= 1'b0;
    end else begin
      fetch_en  <= 1'b1;
      in_flight <= in_flight_nxt;
      if (jump_flag_in) begin
        pc      <= word_align(jump_addr_in);
        discard <= in_flight_nxt;
      end else begin
        if (req_fire) begin
          pc <= pc + PC_STEP;
        end
        if (rvalid_ok && discard != '0) begin
          discard <= discard - 1'b1;
        end
      end
    end
  end

`ifdef CORE_IF_PROTOCOL_CHECKS
  // flag memory responses that arrive with no request outstanding
  always @(posedge clk) begin
    if (rst && imem_rvalid_in && in_flight == '0) begin
      $error("core_if: rvalid with no request in flight");
    end
  end
`endif

endmodule

// File: tb/tb_core_if.sv
module tb_core_if;
  localparam logic [31:0] DATA_KEY = 32'h5A5A_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        jump_flag_in;
  logic [31:0] jump_addr_in;
  logic        hold_in;
  logic        inst_valid_out;
  logic        inst_ready_in;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;

  int          n_tests;
  int          n_fail;
  bit          mem_pause;
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] gnt_log[$];
  logic [31:0] ra[$];
  logic [31:0] va[$];
  int          rc[$];
  int          vc[$];
  bit          seen;
  logic [31:0] first_valid;
  int          cnt;

  // Depth 4 lets a zero-wait memory sustain one fetch per cycle.
  core_if #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_out   (imem_req_out),
    .imem_addr_out  (imem_addr_out),
    .imem_gnt_in    (imem_gnt_in),
    .imem_rvalid_in (imem_rvalid_in),
    .imem_rdata_in  (imem_rdata_in),
    .jump_flag_in   (jump_flag_in),
    .jump_addr_in   (jump_addr_in),
    .hold_in        (hold_in),
    .inst_valid_out (inst_valid_out),
    .inst_ready_in  (inst_ready_in),
    .inst_out       (inst_out),
    .inst_addr_out  (inst_addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // inputs change 1 ns after the falling edge, outputs are read 3 ns after it
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // memory: answers granted reads in order, one cycle after the grant at the earliest
  task automatic memory();
    forever begin
      @(negedge clk);
      #2;
      if (!mem_pause && mq.size() > 0) begin
        imem_rvalid_in = 1'b1;
        imem_rdata_in  = mq.pop_front() ^ DATA_KEY;
      end else begin
        imem_rvalid_in = 1'b0;
        imem_rdata_in  = '0;
      end
      if (imem_req_out && imem_gnt_in) mq.push_back(imem_addr_out);
    end
  endtask

  // monitor: every accepted output must be the next expected address with its data
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst && inst_valid_out && inst_ready_in) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got addr 0x%08h, expected no output", inst_addr_out);
        end else begin
          e = exp_q.pop_front();
          chk("out_addr", inst_addr_out, e);
          chk("out_data", inst_out, e ^ DATA_KEY);
        end
      end
    end
  endtask

  task automatic do_reset();
    step();
    rst           = 1'b0;
    hold_in       = 1'b0;
    jump_flag_in  = 1'b0;
    jump_addr_in  = '0;
    inst_ready_in = 1'b1;
    imem_gnt_in   = 1'b1;
    mem_pause     = 1'b0;
    mq.delete();
    exp_q.delete();
    settle();
    chk("rst_req",   {31'd0, imem_req_out},   32'd0);
    chk("rst_valid", {31'd0, inst_valid_out}, 32'd0);
    chk("rst_inst",  inst_out,      NOP);
    chk("rst_addr",  inst_addr_out, 32'h0);
    step();
    step();
    rst = 1'b1;
  endtask

  // run with hold low until n grants happen; caller raises hold on the next cycle
  task automatic fetch_n(input string name, input int n);
    int guard;
    cnt = 0;
    guard = 0;
    gnt_log.delete();
    while (cnt < n && guard < 30) begin
      step();
      hold_in = 1'b0;
      settle();
      if (imem_req_out && imem_gnt_in) begin
        cnt++;
        gnt_log.push_back(imem_addr_out);
      end
      guard++;
    end
    chk(name, cnt, n);
  endtask

  task automatic hold_next();
    step();
    hold_in = 1'b1;
    settle();
  endtask

  task automatic drain(input int cycles);
    seen = 1'b0;
    first_valid = '0;
    for (int c = 0; c < cycles; c++) begin
      step();
      settle();
      if (!seen && inst_valid_out && inst_ready_in) begin
        seen = 1'b1;
        first_valid = inst_addr_out;
      end
    end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b0;
    imem_gnt_in    = 1'b0;
    imem_rvalid_in = 1'b0;
    imem_rdata_in  = '0;
    jump_flag_in   = 1'b0;
    jump_addr_in   = '0;
    hold_in        = 1'b0;
    inst_ready_in  = 1'b0;
    mem_pause      = 1'b0;

    fork
      memory();
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // 1: zero-wait memory, ready high; three fetches stream back to back
    do_reset();
    exp_q = {32'h0, 32'h4, 32'h8};
    ra.delete(); rc.delete(); va.delete(); vc.delete();
    for (int c = 0; c < 10; c++) begin
      step();
      hold_in = (ra.size() >= 3);
      settle();
      if (imem_req_out && imem_gnt_in) begin ra.push_back(imem_addr_out); rc.push_back(c); end
      if (inst_valid_out) begin va.push_back(inst_addr_out); vc.push_back(c); end
    end
    chk("t1_req_count", ra.size(), 3);
    chk("t1_valid_count", va.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_req_addr%0d", i), (ra.size() > i) ? ra[i] : 32'hDEAD_BEEF, 32'(4 * i));
      chk($sformatf("t1_out_addr%0d", i), (va.size() > i) ? va[i] : 32'hDEAD_BEEF, 32'(4 * i));
    end
    chk("t1_req_back_to_back", (rc.size() == 3) ? 32'(rc[2] - rc[0]) : 32'hFFFF_FFFF, 32'd2);
    chk("t1_out_back_to_back", (vc.size() == 3) ? 32'(vc[2] - vc[0]) : 32'hFFFF_FFFF, 32'd2);
    drain(4);
    chk("t1_drained", exp_q.size(), 0);

    // 2: downstream stalled; fetch stops after DEPTH requests, then drains in order
    do_reset();
    inst_ready_in = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      settle();
      if (imem_req_out && imem_gnt_in) cnt++;
    end
    chk("t2_req_count", cnt, DEPTH);
    chk("t2_req_stopped", {31'd0, imem_req_out}, 32'd0);
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
    vc.delete();
    for (int c = 0; c < 6; c++) begin
      step();
      inst_ready_in = 1'b1;
      hold_in = 1'b1;
      settle();
      if (inst_valid_out) vc.push_back(c);
    end
    chk("t2_valid_cycles", vc.size(), 4);
    chk("t2_no_gaps", (vc.size() == 4) ? 32'(vc[3] - vc[0]) : 32'hFFFF_FFFF, 32'd3);
    chk("t2_drained", exp_q.size(), 0);

    // 3: redirect to 0x100 with one entry buffered and two reads in flight
    do_reset();
    inst_ready_in = 1'b0;
    fetch_n("t3_fetch_a", 1);
    hold_next();
    mem_pause = 1'b1;
    fetch_n("t3_fetch_b", 2);
    hold_next();
    chk("t3_pre_jump_valid", {31'd0, inst_valid_out}, 32'd1);
    chk("t3_pre_jump_addr", inst_addr_out, 32'h0);
    step();
    hold_in      = 1'b0;
    jump_flag_in = 1'b1;
    jump_addr_in = 32'h0000_0100;
    settle();
    chk("t3_no_req_in_jump", {31'd0, imem_req_out}, 32'd0);
    step();
    jump_flag_in = 1'b0;
    hold_in      = 1'b1;
    settle();
    chk("t3_flushed", {31'd0, inst_valid_out}, 32'd0);
    inst_ready_in = 1'b1;
    mem_pause     = 1'b0;
    exp_q = {32'h100, 32'h104};
    fetch_n("t3_fetch_c", 2);
    chk("t3_target_addr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, 32'h100);
    hold_next();
    drain(10);
    chk("t3_first_valid", seen ? first_valid : 32'hDEAD_BEEF, 32'h100);
    chk("t3_drained", exp_q.size(), 0);

    // 4: misaligned redirect during hold; fetch resumes at the word address
    do_reset();
    hold_in = 1'b1;
    step();
    step();
    step();
    jump_flag_in = 1'b1;
    jump_addr_in = 32'h0000_0103;
    settle();
    chk("t4_no_req_in_jump", {31'd0, imem_req_out}, 32'd0);
    step();
    jump_flag_in = 1'b0;
    settle();
    chk("t4_aligned_addr", imem_addr_out, 32'h100);
    chk("t4_hold_no_req", {31'd0, imem_req_out}, 32'd0);
    exp_q = {32'h100};
    fetch_n("t4_fetch", 1);
    chk("t4_fetch_addr", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, 32'h100);
    hold_next();
    drain(6);
    chk("t4_drained", exp_q.size(), 0);

    // 5: grant withheld keeps the request stable; hold blocks requests but not responses
    do_reset();
    exp_q = {32'h0, 32'h4, 32'h8};
    fetch_n("t5_fetch", 2);
    for (int i = 0; i < 3; i++) begin
      step();
      hold_in = 1'b0;
      imem_gnt_in = 1'b0;
      settle();
      chk($sformatf("t5_stall_req%0d", i), {31'd0, imem_req_out}, 32'd1);
      chk($sformatf("t5_stall_addr%0d", i), imem_addr_out, 32'h8);
    end
    step();
    imem_gnt_in = 1'b1;
    settle();
    chk("t5_grant", {31'd0, imem_req_out & imem_gnt_in}, 32'd1);
    chk("t5_grant_addr", imem_addr_out, 32'h8);
    hold_next();
    chk("t5_hold_no_req", {31'd0, imem_req_out}, 32'd0);
    step();
    settle();
    chk("t5_resp_in_hold_valid", {31'd0, inst_valid_out}, 32'd1);
    chk("t5_resp_in_hold_addr", inst_addr_out, 32'h8);
    drain(4);
    chk("t5_drained", exp_q.size(), 0);

    // 6: reset with one read outstanding; its late response must not surface
    do_reset();
    inst_ready_in = 1'b0;
    fetch_n("t6_fetch", 2);
    step();
    hold_in   = 1'b1;
    mem_pause = 1'b1;
    settle();
    chk("t6_pre_valid", {31'd0, inst_valid_out}, 32'd1);
    chk("t6_pre_addr", inst_addr_out, 32'h0);
    step();
    hold_in = 1'b0;
    rst     = 1'b0;
    settle();
    chk("t6_rst_valid", {31'd0, inst_valid_out}, 32'd0);
    chk("t6_rst_inst", inst_out, NOP);
    chk("t6_rst_addr", inst_addr_out, 32'h0);
    chk("t6_rst_req", {31'd0, imem_req_out}, 32'd0);
    step();
    rst       = 1'b1;
    hold_in   = 1'b1;
    mem_pause = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      chk($sformatf("t6_stale_ignored%0d", i), {31'd0, inst_valid_out}, 32'd0);
    end
    inst_ready_in = 1'b1;
    exp_q = {32'h0};
    fetch_n("t6_refetch", 1);
    chk("t6_restart_pc", (gnt_log.size() > 0) ? gnt_log[0] : 32'hDEAD_BEEF, 32'h0);
    hold_next();
    drain(6);
    chk("t6_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
